muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the execute stage. It accepts MULT/DIV operations from the decoded ALU opcode stream and runs an iterative 32-step shift-add multiply or restoring divide. It serves MFHI/MFLO reads and generates a pipeline stall whenever an instruction needs HI/LO, or the unit itself, while an operation is in flight.

## Interface

Parameters:
- MULT_OP, default 6'b000010, aluop code that starts a multiply
- DIV_OP, default 6'b000011, aluop code that starts a divide
- MFHI_OP, default 6'b000100, aluop code that reads HI
- MFLO_OP, default 6'b000101, aluop code that reads LO

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- valid  input  1  aluop/rA/rB describe a live instruction this cycle
- aluop  input  6  decoded ALU opcode
- rA  input  32  operand A (multiplicand / dividend)
- rB  input  32  operand B (multiplier / divisor)
- stall  output  1  combinational; hold the execute stage this cycle
- busy  output  1  registered; an operation is in flight
- mfOut  output  32  combinational; HI for MFHI_OP, LO for MFLO_OP, else 0
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

## Operation

- States: IDLE, RUN. A 5-bit step counter is used in RUN.
- Issue: in IDLE, valid & (aluop==MULT_OP or DIV_OP) latches the operands; the next state is RUN with counter=0.
- MULT: unsigned 32x32, full 64-bit product; one shift-add step per cycle; hi=product[63:32], lo=product[31:0].
- DIV: unsigned restoring divide, one quotient bit per cycle; lo=quotient, hi=remainder.
- Divide by zero (rB==0 at issue): no RUN phase; the unit completes at the issue edge with lo=32'hFFFFFFFF and hi=rA; busy stays 0.
- RUN: at the edge where counter==31, the result is written to hi/lo and the state returns to IDLE. hi/lo hold their old values during RUN.
- stall = valid & busy & (aluop is MULT_OP, DIV_OP, MFHI_OP or MFLO_OP). All other aluops never stall.
- A stalled MULT/DIV issues at the edge where busy falls. It never overwrites an in-flight operation.
- mfOut is driven whenever valid and aluop is MFHI_OP/MFLO_OP, and is meaningful when stall==0.
- Reset (any time, including mid-RUN): state=IDLE, counter=0, busy=0, hi=0, lo=0, and the operand/accumulator registers are cleared. The in-flight result is discarded.

## Timing

- Issue edge ends cycle 0. busy=1 in cycles 1..32. hi/lo are updated at the edge ending cycle 32. busy=0 in cycle 33.
- Latency: 32 cycles from issue to result visible. An MFHI/MFLO in cycle 33 returns the new value without stall.
- MFHI/MFLO or MULT/DIV presented in cycles 1..32 has stall=1 for every one of those cycles.
- Back-to-back: a MULT/DIV held by stall issues at the end of cycle 32. The next busy period runs cycles 33..64.
- Divide by zero: hi/lo are updated at the issue edge; a read in cycle 1 sees them with no stall.
- Reset asserted: outputs go to 0 immediately (asynchronous). The first issue is accepted at the first edge after deassertion.

## Configuration

- MULDIV_SIGNED_EN defined: MULT and DIV are two's-complement signed.
  - Operands are converted to magnitudes at issue, and the sign is fixed up on write-back.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero gives lo=32'hFFFFFFFF and hi=rA.
  - Latency is unchanged at 32 cycles.
- MULDIV_SIGNED_EN undefined: MULT and DIV are purely unsigned, as described above. No sign logic is built.

## Test plan

- MULT rA=7, rB=6 -> busy for 32 cycles; then hi=0, lo=42; MFLO in cycle 33 gives mfOut=42 with stall=0.
- MULT rA=32'hFFFFFFFF, rB=2 -> hi=32'h00000001, lo=32'hFFFFFFFE.
- DIV rA=100, rB=7; MFLO presented in cycle 1 -> stall=1 for cycles 1..32; mfOut=14 in cycle 33; MFHI then gives 2.
- DIV rA=5, rB=0 -> busy never asserts; lo=32'hFFFFFFFF, hi=5 in cycle 1.
- MULT issued, reset pulsed in cycle 10 -> busy=0, hi=lo=0 immediately; a new DIV 9/3 after reset gives lo=3, hi=0 at 32 cycles.
- With MULDIV_SIGNED_EN: DIV rA=-7, rB=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). MULT -3 x 4 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF4.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative 32-step multiply/divide sequencer owning HI/LO; stalls the execute stage on HI/LO or unit hazards.
// Define MULDIV_SIGNED_EN for two's-complement MULT/DIV (magnitude datapath with sign fix-up on write-back).
module muldiv_ctrl #(
    parameter logic [5:0] MULT_OP = 6'b000010,
    parameter logic [5:0] DIV_OP  = 6'b000011,
    parameter logic [5:0] MFHI_OP = 6'b000100,
    parameter logic [5:0] MFLO_OP = 6'b000101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  aluop,
    input  logic [31:0] rA,
    input  logic [31:0] rB,
    output logic        stall,
    output logic        busy,
    output logic [31:0] mfOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd_b;
    logic        op_div;
    logic        is_md, last, issue, div_zero;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, rem_sh, diff;
    logic [63:0] acc_nxt, wb;

    assign is_md    = (aluop == MULT_OP) || (aluop == DIV_OP);
    assign last     = (state == RUN) && (cnt == 5'd31);
    // The finishing edge doubles as an issue slot so a stalled op starts without a bubble.
    assign issue    = valid && is_md && ((state == IDLE) || last);
    assign div_zero = issue && (aluop == DIV_OP) && (rB == 32'd0);

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_r;
    assign mag_a = rA[31] ? (32'd0 - rA) : rA;
    assign mag_b = rB[31] ? (32'd0 - rB) : rB;
`else
    assign mag_a = rA;
    assign mag_b = rB;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            if (issue && !div_zero)
                cnt <= 5'd0;
            else if (state == RUN)
                cnt <= cnt + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue && !div_zero) state_nxt = RUN;
            RUN:  if (last) state_nxt = (issue && !div_zero) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = valid && busy && (is_md || (aluop == MFHI_OP) || (aluop == MFLO_OP));
        mfOut = 32'd0;
        if (valid && (aluop == MFHI_OP))
            mfOut = hi;
        else if (valid && (aluop == MFLO_OP))
            mfOut = lo;
    end

    // Multiply: acc = {partial, multiplier}, add-then-shift-right.
    // Divide:   acc = {remainder, dividend/quotient}, shift-left-then-trial-subtract.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
        rem_sh  = acc[63:31];
        diff    = rem_sh - {1'b0, opnd_b};
        if (op_div)
            acc_nxt = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                               : {diff[31:0],   acc[30:0], 1'b1};
        else
            acc_nxt = {mul_sum, acc[31:1]};
        wb = acc_nxt;
`ifdef MULDIV_SIGNED_EN
        if (op_div) begin
            if (neg_q) wb[31:0]  = 32'd0 - acc_nxt[31:0];
            if (neg_r) wb[63:32] = 32'd0 - acc_nxt[63:32];
        end else if (neg_q) begin
            wb = 64'd0 - acc_nxt;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= 64'd0;
            opnd_b <= 32'd0;
            op_div <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            if (last) begin
                hi <= wb[63:32];
                lo <= wb[31:0];
            end else if (state == RUN) begin
                acc <= acc_nxt;
            end
            if (issue) begin
                if (div_zero) begin
                    hi <= rA;
                    lo <= 32'hFFFF_FFFF;
                end else begin
                    acc    <= {32'd0, mag_a};
                    opnd_b <= mag_b;
                    op_div <= (aluop == DIV_OP);
`ifdef MULDIV_SIGNED_EN
                    neg_q  <= rA[31] ^ rB[31];
                    neg_r  <= rA[31];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + randomized bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam logic [5:0] OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011;
    localparam logic [5:0] OP_MFHI = 6'b000100;
    localparam logic [5:0] OP_MFLO = 6'b000101;

    logic        clock = 1'b0;
    logic        reset, valid;
    logic [5:0]  aluop;
    logic [31:0] rA, rB;
    logic        stall, busy;
    logic [31:0] mfOut, hi, lo;

    int total  = 0;
    int passed = 0;

    muldiv_ctrl dut (
        .clock (clock),
        .reset (reset),
        .valid (valid),
        .aluop (aluop),
        .rA    (rA),
        .rB    (rB),
        .stall (stall),
        .busy  (busy),
        .mfOut (mfOut),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
`ifdef MULDIV_SIGNED_EN
        longint sa, sb, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        longint unsigned sa, sb, q, r, p;
        sa = longint'(a);
        sb = longint'(b);
`endif
        if (is_div && b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (is_div) begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end else begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end
    endfunction

    task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input bit rd);
        logic [31:0] eh, el, oh, ol;
        int n, ns;
        bit dz;
        model(is_div, a, b, eh, el);
        dz = is_div && (b == 32'd0);
        oh = hi;
        ol = lo;
        valid = 1'b1;
        aluop = is_div ? OP_DIV : OP_MUL;
        rA = a;
        rB = b;
        #1;
        chk("issue_stall", 32'(stall), 32'd0);
        tick;
        valid = rd;
        aluop = OP_MFLO;
        #1;
        n = 0;
        ns = 0;
        while (busy === 1'b1 && n < 40) begin
            if (stall === 1'b1) ns++;
            if (n == 16) begin
                chk("run_hold_hi", hi, oh);
                chk("run_hold_lo", lo, ol);
            end
            n++;
            tick;
        end
        chk("busy_cycles", 32'(n), dz ? 32'd0 : 32'd32);
        chk("stall_cycles", 32'(ns), (rd && !dz) ? 32'd32 : 32'd0);
        valid = 1'b1;
        aluop = OP_MFLO;
        #1;
        chk("read_stall", 32'(stall), 32'd0);
        chk("mflo", mfOut, el);
        aluop = OP_MFHI;
        #1;
        chk("mfhi", mfOut, eh);
        chk("hi_reg", hi, eh);
        chk("lo_reg", lo, el);
        valid = 1'b0;
        aluop = OP_MFLO;
        #1;
        chk("mf_novalid", mfOut, 32'd0);
    endtask

    initial begin
        logic [31:0] eh1, el1, eh2, el2, a, b;
        int n, ns;
        bit d;

        reset = 1'b1;
        valid = 1'b0;
        aluop = 6'd0;
        rA = 32'd0;
        rB = 32'd0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        valid = 1'b1;
        aluop = OP_MFHI;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mfout", mfOut, 32'd0);
        valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'd6, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(1'b1, 32'd100, 32'd7, 1'b1);
        do_op(1'b1, 32'd5, 32'd0, 1'b1);
        do_op(1'b0, 32'd1234, 32'd5678, 1'b0);

        // Reset mid-run, with other aluops probed for stall first.
        valid = 1'b1;
        aluop = OP_MUL;
        rA = 32'h0001_0000;
        rB = 32'h0003_0000;
        #1;
        tick;
        aluop = 6'd0;
        #1;
        chk("other_op_stall", 32'(stall), 32'd0);
        aluop = OP_MFHI;
        #1;
        chk("mfhi_busy_stall", 32'(stall), 32'd1);
        valid = 1'b0;
        for (int k = 0; k < 9; k++) tick;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        #1;
        reset = 1'b0;
        do_op(1'b1, 32'd9, 32'd3, 1'b0);

        // Back-to-back: a DIV held by stall issues at the end of cycle 32.
        model(1'b0, 32'hDEAD_BEEF, 32'h0000_1001, eh1, el1);
        model(1'b1, 32'hCAFE_F00D, 32'd77, eh2, el2);
        valid = 1'b1;
        aluop = OP_MUL;
        rA = 32'hDEAD_BEEF;
        rB = 32'h0000_1001;
        #1;
        tick;
        aluop = OP_DIV;
        rA = 32'hCAFE_F00D;
        rB = 32'd77;
        #1;
        ns = 0;
        for (int k = 0; k < 32; k++) begin
            if (stall === 1'b1) ns++;
            tick;
        end
        valid = 1'b0;
        #1;
        chk("b2b_stalls", 32'(ns), 32'd32);
        chk("b2b_busy_again", 32'(busy), 32'd1);
        chk("b2b_first_hi", hi, eh1);
        chk("b2b_first_lo", lo, el1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        chk("b2b_second_busy", 32'(n), 32'd32);
        chk("b2b_second_hi", hi, eh2);
        chk("b2b_second_lo", lo, el2);

        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            do_op(d, a, b, 1'($urandom_range(0, 1)));
        end

`ifdef MULDIV_SIGNED_EN
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFD, 32'd4, 1'b0);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
